// File: rtl/eater_pkg.sv
// Shared opcode map, control-word bit positions and the microcode table
// for the SAP-style sequencer.
package eater_pkg;

  localparam int CTRL_W = 16;
  localparam int STEP_W = 3;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int CTL_HLT = 15;
  localparam int CTL_MI  = 14;
  localparam int CTL_RI  = 13;
  localparam int CTL_RO  = 12;
  localparam int CTL_IO  = 11;
  localparam int CTL_II  = 10;
  localparam int CTL_AI  = 9;
  localparam int CTL_AO  = 8;
  localparam int CTL_EO  = 7;
  localparam int CTL_SU  = 6;
  localparam int CTL_BI  = 5;
  localparam int CTL_OI  = 4;
  localparam int CTL_CE  = 3;
  localparam int CTL_CO  = 2;
  localparam int CTL_J   = 1;
  localparam int CTL_FI  = 0;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} run_state_e;

  function automatic logic [CTRL_W-1:0] bitw(input int idx);
    logic [CTRL_W-1:0] w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  // T0/T1 fetch is common; T2..T4 depend on opcode (and on flags for JC/JZ).
  function automatic logic [CTRL_W-1:0] ucode(input logic [3:0] opcode,
                                               input logic [STEP_W-1:0] step,
                                               input logic c, input logic z);
    logic [CTRL_W-1:0] w;
    w = '0;
    case (step)
      3'd0: w = bitw(CTL_CO) | bitw(CTL_MI);
      3'd1: w = bitw(CTL_RO) | bitw(CTL_II) | bitw(CTL_CE);
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: w = bitw(CTL_IO) | bitw(CTL_MI);
          OP_LDI: w = bitw(CTL_IO) | bitw(CTL_AI);
          OP_JMP: w = bitw(CTL_IO) | bitw(CTL_J);
          OP_JC:  w = c ? (bitw(CTL_IO) | bitw(CTL_J)) : '0;
          OP_JZ:  w = z ? (bitw(CTL_IO) | bitw(CTL_J)) : '0;
          OP_OUT: w = bitw(CTL_AO) | bitw(CTL_OI);
          OP_HLT: w = bitw(CTL_HLT);
          default: w = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: w = bitw(CTL_RO) | bitw(CTL_AI);
          OP_ADD, OP_SUB: w = bitw(CTL_RO) | bitw(CTL_BI);
          OP_STA: w = bitw(CTL_AO) | bitw(CTL_RI);
          default: w = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD: w = bitw(CTL_EO) | bitw(CTL_AI) | bitw(CTL_FI);
          OP_SUB: w = bitw(CTL_EO) | bitw(CTL_AI) | bitw(CTL_SU) | bitw(CTL_FI);
          default: w = '0;
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/eater_control_seq_if.sv
// Sequencer-to-datapath bundle: opcode and flags in, step/halt/control word out.
interface eater_control_seq_if;
  import eater_pkg::*;

  logic [3:0]        opcode;
  logic              flag_c;
  logic              flag_z;
  logic [STEP_W-1:0] step;
  logic              halted;
  logic [CTRL_W-1:0] ctrl;

  modport master (input opcode, flag_c, flag_z, output step, halted, ctrl);
  modport slave  (output opcode, flag_c, flag_z, input step, halted, ctrl);
endinterface

// File: rtl/eater_step_counter.sv
// Microstep counter advancing on the falling clock edge, with hold and
// synchronous restart-to-zero.
module eater_step_counter
  import eater_pkg::*;
#(
  parameter int NUM_STEPS = 5
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              i_restart,
  input  logic              i_hold,
  output logic [STEP_W-1:0] o_step
);

  logic [STEP_W-1:0] r_step;

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_step <= '0;
    end else if (i_hold) begin
      r_step <= r_step;
    end else if (i_restart || r_step == STEP_W'(NUM_STEPS - 1)) begin
      r_step <= '0;
    end else begin
      r_step <= r_step + STEP_W'(1);
    end
  end

  assign o_step = r_step;

endmodule

// File: rtl/eater_control_seq.sv
// Microcode sequencer top: holds the sticky halt state and muxes the
// control word from the microcode table.
module eater_control_seq
  import eater_pkg::*;
#(
  parameter int NUM_STEPS   = 5,
  parameter int EARLY_RESET = 1
) (
  input  logic                clk,
  input  logic                clr_n,
  eater_control_seq_if.master bus
);

  run_state_e        r_state;
  logic [STEP_W-1:0] w_step;
  logic [CTRL_W-1:0] w_ucode;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_hold;
  logic              w_restart;

  assign w_ucode = ucode(bus.opcode, w_step, bus.flag_c, bus.flag_z);
  assign w_ctrl  = (r_state == ST_HALT) ? bitw(CTL_HLT) : w_ucode;

  // The halting negedge itself must not advance the step, hence ctrl[HLT] in hold.
  assign w_hold    = (r_state == ST_HALT) || w_ctrl[CTL_HLT];
  assign w_restart = (EARLY_RESET != 0) && (w_step >= STEP_W'(2)) && (w_ctrl == '0);

  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  if (w_ctrl[CTL_HLT]) r_state <= ST_HALT;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  eater_step_counter #(.NUM_STEPS(NUM_STEPS)) u_step (
    .clk       (clk),
    .clr_n     (clr_n),
    .i_restart (w_restart),
    .i_hold    (w_hold),
    .o_step    (w_step)
  );

  assign bus.step   = w_step;
  assign bus.halted = (r_state == ST_HALT);
  assign bus.ctrl   = w_ctrl;

endmodule
